prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 32 +++
 rtl/loader_timeout.sv | 28 ++
 rtl/prog_loader.sv | 150 +++++++++++++++
 tb/tb_prog_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared CPU definitions: loader state encoding, program RAM size and opcode map.
// Imported by the program loader and its timeout helper.
package prog_loader_pkg;

   localparam int MAX_PROG_BYTES = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } ld_state_t;

   typedef enum logic [3:0] {
      OP_LDA = 4'b1000,
      OP_LDB = 4'b0100,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0001,
      OP_MUL = 4'b1100,
      OP_DIV = 4'b1010,
      OP_JMP = 4'b1001,
      OP_HLT = 4'b1111
   } opcode_t;

   // A length byte is usable only if the whole program fits in RAM.
   function automatic logic len_ok(input logic [7:0] n);
      return (n != 8'd0) && (n <= 8'(MAX_PROG_BYTES));
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for the loader: counts enabled cycles since the last clear
// and flags expiry on the cycle that would reach TIMEOUT_CYCLES.
module loader_timeout #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expire
);

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] r_cnt;

   // Expiry is asserted during the TIMEOUT_CYCLES-th idle cycle itself.
   assign o_expire = i_en && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expire) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives length, payload and checksum bytes and writes
// the payload into the 16x8 program RAM while holding the CPU in reset.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       wr_en,
   output logic [3:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       cpu_hold,
   output logic       done,
   output logic       err
);

   ld_state_t  r_state;
   logic       r_in_ready;
   logic       r_wr_en;
   logic [3:0] r_wr_addr;
   logic [7:0] r_wr_data;
   logic       r_cpu_hold;
   logic       r_done;
   logic       r_err;
   logic [4:0] r_remaining;
   logic [3:0] r_idx;
   logic [7:0] r_csum;

   logic w_busy;
   logic w_xfer;
   logic w_enter;
   logic w_expire;
   logic w_fail;

   assign w_busy  = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
   assign w_xfer  = in_valid && r_in_ready;
   assign w_enter = !w_busy && start;

   loader_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_busy),
      .i_clr    (w_xfer || w_enter),
      .o_expire (w_expire)
   );

   // A transfer always takes precedence over a coincident timeout expiry.
   always_comb begin
      w_fail = 1'b0;
      if (w_busy) begin
         if (w_xfer) begin
            case (r_state)
               ST_LEN:  w_fail = !len_ok(in_data);
               ST_CSUM: w_fail = (in_data != r_csum);
               default: w_fail = 1'b0;
            endcase
         end else begin
            w_fail = w_expire;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_cpu_hold  <= 1'b1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_remaining <= '0;
         r_idx       <= '0;
         r_csum      <= '0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_fail) begin
            r_state    <= ST_ERR;
            r_in_ready <= 1'b0;
            r_err      <= 1'b1;
            r_done     <= 1'b0;
            r_cpu_hold <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE, ST_DONE, ST_ERR: begin
                  if (start) begin
                     r_state     <= ST_LEN;
                     r_in_ready  <= 1'b1;
                     r_done      <= 1'b0;
                     r_err       <= 1'b0;
                     r_cpu_hold  <= 1'b1;
                     r_remaining <= '0;
                     r_idx       <= '0;
                     r_csum      <= '0;
                  end
               end
               ST_LEN: begin
                  if (w_xfer) begin
                     r_state     <= ST_DATA;
                     r_remaining <= in_data[4:0];
                     r_idx       <= '0;
                  end
               end
               ST_DATA: begin
                  if (w_xfer) begin
                     r_wr_en     <= 1'b1;
                     r_wr_addr   <= r_idx;
                     r_wr_data   <= in_data;
                     r_idx       <= r_idx + 4'd1;
                     r_csum      <= r_csum + in_data;
                     r_remaining <= r_remaining - 5'd1;
                     if (r_remaining == 5'd1) begin
                        r_state <= ST_CSUM;
                     end
                  end
               end
               ST_CSUM: begin
                  if (w_xfer) begin
                     r_state    <= ST_DONE;
                     r_in_ready <= 1'b0;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                  end
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_in_ready <= 1'b0;
               end
            endcase
         end
      end
   end

   assign in_ready = r_in_ready;
   assign wr_en    = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign cpu_hold = r_cpu_hold;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad loads, length limits, timeout edge,
// long load with gaps and mid-load reset.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       cpu_hold;
   logic       done;
   logic       err;

   int errors = 0;
   int checks = 0;

   prog_loader #(.TIMEOUT_CYCLES(255)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Write/accept log sampled on the falling edge.
   int         cyc = 0;
   int         nwr = 0;
   int         nacc = 0;
   logic [3:0] wa [0:63];
   logic [7:0] wd [0:63];
   int         wc [0:63];
   int         ac [0:255];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (wr_en && nwr < 64) begin
         wa[nwr] <= wr_addr;
         wd[nwr] <= wr_data;
         wc[nwr] <= cyc;
         nwr     <= nwr + 1;
      end
      if (in_valid && in_ready && nacc < 256) begin
         ac[nacc] <= cyc;
         nacc     <= nacc + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h03;
      idle(2);
      reset = 1'b0; start = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
      checks++; if (wr_addr !== 4'h0 || wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_bus got=%h/%h exp=0/00", wr_addr, wr_data); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got done=%b err=%b exp=0/0", done, err); end
      checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
      idle(3);
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0 || nwr !== 0) begin errors++; $display("FAIL idle_ignores_valid got ready=%b writes=%0d exp=0/0", in_ready, nwr); end
   endtask

   task automatic test_good_load;
      int bw, ba;
      logic [7:0] exp_d [0:2];
      exp_d[0] = 8'h18; exp_d[1] = 8'h28; exp_d[2] = 8'hF0;
      pulse_start;
      checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin errors++; $display("FAIL start_enters_len got ready=%b hold=%b exp=1/1", in_ready, cpu_hold); end
      bw = nwr; ba = nacc;
      push(8'h03);
      push(8'h18);
      start = 1'b1;
      push(8'h28);
      start = 1'b0;
      push(8'hF0);
      push(8'h30);
      checks++; if (nwr - bw !== 3) begin errors++; $display("FAIL good_write_count got=%0d exp=3", nwr - bw); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (wa[bw+i] !== 4'(i) || wd[bw+i] !== exp_d[i]) begin errors++; $display("FAIL good_write%0d got=%h:%h exp=%h:%h", i, wa[bw+i], wd[bw+i], 4'(i), exp_d[i]); end
         checks++; if (wc[bw+i] !== ac[ba+1+i] + 1) begin errors++; $display("FAIL good_latency%0d got=%0d exp=%0d", i, wc[bw+i], ac[ba+1+i] + 1); end
      end
      checks++; if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL good_done got done=%b err=%b hold=%b exp=1/0/0", done, err, cpu_hold); end
      in_valid = 1'b1; in_data = 8'h55;
      idle(5);
      in_valid = 1'b0;
      checks++; if (done !== 1'b1 || in_ready !== 1'b0 || nwr - bw !== 3) begin errors++; $display("FAIL done_held got done=%b ready=%b writes=%0d exp=1/0/3", done, in_ready, nwr - bw); end
   endtask

   task automatic test_bad_csum;
      int bw;
      pulse_start;
      checks++; if (done !== 1'b0 || err !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL restart_clears got done=%b err=%b hold=%b exp=0/0/1", done, err, cpu_hold); end
      bw = nwr;
      push(8'h02); push(8'h84); push(8'h85); push(8'h00);
      checks++; if (nwr - bw !== 2 || wd[bw] !== 8'h84 || wd[bw+1] !== 8'h85) begin errors++; $display("FAIL badcsum_writes got n=%0d", nwr - bw); end
      checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL badcsum_err got err=%b done=%b hold=%b exp=1/0/1", err, done, cpu_hold); end
      idle(4);
      checks++; if (err !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL err_held got err=%b ready=%b exp=1/0", err, in_ready); end
   endtask

   task automatic test_bad_len;
      int bw;
      bw = nwr;
      pulse_start;
      push(8'h00);
      checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL len0_err got err=%b done=%b exp=1/0", err, done); end
      pulse_start;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL len_restart got err=%b exp=0", err); end
      push(8'h11);
      idle(2);
      checks++; if (err !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL len17_err got err=%b ready=%b exp=1/0", err, in_ready); end
      checks++; if (nwr - bw !== 0) begin errors++; $display("FAIL badlen_no_writes got=%0d exp=0", nwr - bw); end
   endtask

   task automatic test_timeout;
      int bw;
      pulse_start;
      push(8'h02); push(8'hFF);
      idle(254);
      checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL tmo_before got err=%b ready=%b exp=0/1", err, in_ready); end
      idle(1);
      checks++; if (err !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL tmo_expire got err=%b done=%b ready=%b exp=1/0/0", err, done, in_ready); end
      pulse_start;
      bw = nwr;
      push(8'h02); push(8'hFF);
      idle(254);
      push(8'h01);
      checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL tmo_xfer_wins got err=%b ready=%b exp=0/1", err, in_ready); end
      push(8'h00);
      checks++; if (done !== 1'b1 || nwr - bw !== 2 || wa[bw+1] !== 4'h1 || wd[bw+1] !== 8'h01) begin errors++; $display("FAIL tmo_xfer_load got done=%b n=%0d", done, nwr - bw); end
   endtask

   task automatic test_full_gaps;
      int bw;
      int bad;
      pulse_start;
      bw = nwr;
      push(8'h10);
      for (int i = 1; i <= 16; i++) begin
         idle($urandom_range(0, 3));
         push(8'(i));
      end
      idle($urandom_range(0, 3));
      push(8'h88);
      checks++; if (nwr - bw !== 16) begin errors++; $display("FAIL full_write_count got=%0d exp=16", nwr - bw); end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (wa[bw+i] !== 4'(i) || wd[bw+i] !== 8'(i + 1)) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL full_write_order got bad=%0d exp=0", bad); end
      checks++; if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL full_done got done=%b err=%b hold=%b exp=1/0/0", done, err, cpu_hold); end
   endtask

   task automatic test_reset_midload;
      int bw;
      pulse_start;
      bw = nwr;
      push(8'h04); push(8'hA1); push(8'hA2);
      reset = 1'b1; in_valid = 1'b1; in_data = 8'hA3;
      @(posedge clk); #1;
      reset = 1'b0;
      idle(3);
      in_valid = 1'b0;
      idle(2);
      checks++; if (nwr - bw !== 2 || wd[bw+1] !== 8'hA2) begin errors++; $display("FAIL midreset_writes got n=%0d exp=2", nwr - bw); end
      checks++; if (in_ready !== 1'b0 || wr_en !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midreset_idle got ready=%b wr=%b hold=%b done=%b err=%b exp=0/0/1/0/0", in_ready, wr_en, cpu_hold, done, err); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      test_reset;
      test_good_load;
      test_bad_csum;
      test_bad_len;
      test_timeout;
      test_full_gaps;
      test_reset_midload;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
